tile_layer_renderer: RTL

- Generates the game-board layer that feeds the pixel controller's gen_red/gen_green/gen_blue/use_gen inputs.
- Tracks the VGA scan position using incremental tile counters and holds a double-buffered board map of tile types. The map is written by game logic.
- Each in-board pixel is fetched from an external synchronous sprite ROM, with a cursor outline overlaid.
- Output is a fixed 4-cycle pipeline and carries aligned coordinate tags.

---
 rtl/tile_layer_renderer.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/tile_layer_renderer.sv
// Game-board tile layer: tracks the scan position in tile units, holds a double-buffered
// board map, fetches sprite texels from an external ROM and overlays a cursor outline.
module tile_layer_renderer #(
    parameter int unsigned WIDTH    = 12,
    parameter int unsigned BOARD_X0 = 50,
    parameter int unsigned BOARD_Y0 = 50,
    parameter int unsigned TILE     = 50,
    parameter int unsigned ROWS     = 10,
    parameter int unsigned COLS     = 10,
    parameter int unsigned VSIZE    = 600,
    parameter int unsigned CURSOR_W = 2
) (
    input  logic             clk_vga,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] hdata,
    input  logic [WIDTH-1:0] vdata,
    input  logic             wr_en,
    input  logic [3:0]       wr_row,
    input  logic [3:0]       wr_col,
    input  logic [3:0]       wr_type,
    input  logic             commit_req,
    output logic             commit_pending,
    input  logic [3:0]       cursor_row,
    input  logic [3:0]       cursor_col,
    output logic [15:0]      sprite_addr,
    input  logic [23:0]      sprite_data,
    output logic [7:0]       gen_red,
    output logic [7:0]       gen_green,
    output logic [7:0]       gen_blue,
    output logic             use_gen,
    output logic [WIDTH-1:0] out_hdata,
    output logic [WIDTH-1:0] out_vdata
);

    localparam int unsigned PW    = $clog2(TILE);
    localparam int unsigned NT    = ROWS * COLS;
    localparam int unsigned IW    = $clog2(NT);
    localparam int unsigned X_END = BOARD_X0 + COLS * TILE;
    localparam int unsigned Y_END = BOARD_Y0 + ROWS * TILE;

    logic [3:0]       bank_q [2][NT];
    logic             front_q;
    logic             pending_q, pending_d, swap_c;
    logic             wr_ok_c;
    logic [IW-1:0]    wr_idx_c, rd_idx_c;

    // Stage 1: tile counters double as the stage-1 registers
    logic [3:0]       col_q, col_d, row_q, row_d;
    logic [PW-1:0]    px_q, px_d, py_q, py_d;
    logic             valid_q, valid_d, in1_q, in1_d;
    logic [WIDTH-1:0] h1_q, v1_q;

    // Stage 2
    logic [3:0]       type_rd_c, type2_q;
    logic             edge_c, cur_hit_c, in2_q, cur2_q;
    logic [15:0]      addr_d, addr_q;
    logic [WIDTH-1:0] h2_q, v2_q;

    // Stage 3 (sprite_data arrives during this stage)
    logic             opaque3_q, cur3_q;
    logic [WIDTH-1:0] h3_q, v3_q;

    // Stage 4
    logic             use_q;
    logic [7:0]       r_q, g_q, b_q;
    logic [WIDTH-1:0] h4_q, v4_q;

    // Column counter runs every cycle; row counter steps once per line at hdata==0
    always_comb begin
        col_d   = col_q;
        px_d    = px_q;
        row_d   = row_q;
        py_d    = py_q;
        valid_d = valid_q;
        if (hdata == WIDTH'(BOARD_X0)) begin
            col_d = '0;
            px_d  = '0;
        end else if (px_q == PW'(TILE - 1)) begin
            px_d  = '0;
            col_d = col_q + 4'd1;
        end else begin
            px_d = px_q + PW'(1);
        end
        if (hdata == '0) begin
            if (vdata == WIDTH'(BOARD_Y0)) begin
                row_d   = '0;
                py_d    = '0;
                valid_d = 1'b1;
            end else if (py_q == PW'(TILE - 1)) begin
                py_d  = '0;
                row_d = row_q + 4'd1;
            end else begin
                py_d = py_q + PW'(1);
            end
        end
    end

    assign in1_d = valid_d
                && (hdata >= WIDTH'(BOARD_X0)) && (hdata < WIDTH'(X_END))
                && (vdata >= WIDTH'(BOARD_Y0)) && (vdata < WIDTH'(Y_END));

    // Off-board counters can exceed the map; park the read index at 0 there
    assign rd_idx_c  = in1_q ? (IW'(row_q) * IW'(COLS) + IW'(col_q)) : '0;
    assign type_rd_c = in1_q ? bank_q[front_q][rd_idx_c] : 4'd0;
    assign addr_d    = 16'(type_rd_c) * 16'(TILE * TILE) + 16'(py_q) * 16'(TILE) + 16'(px_q);

    assign edge_c    = (px_q < PW'(CURSOR_W)) || (py_q < PW'(CURSOR_W))
                    || (px_q >= PW'(TILE - CURSOR_W)) || (py_q >= PW'(TILE - CURSOR_W));
    assign cur_hit_c = (row_q == cursor_row) && (col_q == cursor_col) && edge_c;

    assign wr_ok_c   = wr_en && (wr_row < 4'(ROWS)) && (wr_col < 4'(COLS));
    assign wr_idx_c  = IW'(wr_row) * IW'(COLS) + IW'(wr_col);

    // Swap only at the start of vblank, so the visible frame never tears
    assign swap_c    = pending_q && (hdata == '0) && (vdata == WIDTH'(VSIZE));
    assign pending_d = commit_req || (pending_q && !swap_c);

    // Writes always target the bank that is back before this edge's swap
    always_ff @(posedge clk_vga or negedge reset_n) begin
        if (!reset_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < int'(NT); i++) begin
                    bank_q[b][i] <= '0;
                end
            end
        end else if (wr_ok_c) begin
            bank_q[~front_q][wr_idx_c] <= wr_type;
        end
    end

    always_ff @(posedge clk_vga or negedge reset_n) begin
        if (!reset_n) begin
            front_q   <= 1'b0;
            pending_q <= 1'b0;
            col_q     <= '0;
            row_q     <= '0;
            px_q      <= '0;
            py_q      <= '0;
            valid_q   <= 1'b0;
            in1_q     <= 1'b0;
            h1_q      <= '0;
            v1_q      <= '0;
            type2_q   <= '0;
            in2_q     <= 1'b0;
            cur2_q    <= 1'b0;
            addr_q    <= '0;
            h2_q      <= '0;
            v2_q      <= '0;
            opaque3_q <= 1'b0;
            cur3_q    <= 1'b0;
            h3_q      <= '0;
            v3_q      <= '0;
            use_q     <= 1'b0;
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
            h4_q      <= '0;
            v4_q      <= '0;
        end else begin
            if (swap_c) begin
                front_q <= ~front_q;
            end
            pending_q <= pending_d;

            col_q     <= col_d;
            row_q     <= row_d;
            px_q      <= px_d;
            py_q      <= py_d;
            valid_q   <= valid_d;
            in1_q     <= in1_d;
            h1_q      <= hdata;
            v1_q      <= vdata;

            type2_q   <= type_rd_c;
            in2_q     <= in1_q;
            cur2_q    <= cur_hit_c;
            addr_q    <= addr_d;
            h2_q      <= h1_q;
            v2_q      <= v1_q;

            opaque3_q <= in2_q && (type2_q != 4'd0);
            cur3_q    <= cur2_q;
            h3_q      <= h2_q;
            v3_q      <= v2_q;

            // Transparency wins over the cursor outline
            use_q     <= opaque3_q;
            if (!opaque3_q) begin
                r_q <= '0;
                g_q <= '0;
                b_q <= '0;
            end else if (cur3_q) begin
                r_q <= 8'hFF;
                g_q <= 8'hFF;
                b_q <= 8'hFF;
            end else begin
                r_q <= sprite_data[7:0];
                g_q <= sprite_data[15:8];
                b_q <= sprite_data[23:16];
            end
            h4_q      <= h3_q;
            v4_q      <= v3_q;
        end
    end

    assign commit_pending = pending_q;
    assign sprite_addr    = addr_q;
    assign gen_red        = r_q;
    assign gen_green      = g_q;
    assign gen_blue       = b_q;
    assign use_gen        = use_q;
    assign out_hdata      = h4_q;
    assign out_vdata      = v4_q;

endmodule
